xnor_pop_sequencer: RTL and testbench

- Control-side initiator that drives the XNOR-popcount neuron engine and packs its 1-bit threshold results into activation words for the next layer.
- Per neuron it clears the engine accumulator, issues chunk read addresses, waits out the engine pipeline, then samples the compare bit.
- Sits between the layer controller (start/done) and the downstream activation buffer (valid/ready stream).

---
 rtl/xnor_pop_pkg.sv | 21 ++
 rtl/xnor_seq_packer.sv | 70 +++++++
 rtl/xnor_pop_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_xnor_pop_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/xnor_pop_pkg.sv
// Shared definitions for the XNOR-popcount neuron sequencer.
//   state_e      : sequencer FSM states
//   DEF_*        : default sizing for the engine buffer depth, layer size,
//                  packed word width and engine pipeline latency
package xnor_pop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_SAMPLE,
        ST_EMIT
    } state_e;

    localparam int DEF_DEPTH    = 8;
    localparam int DEF_MAXN     = 64;
    localparam int DEF_OUT_W    = 8;
    localparam int DEF_PIPE_LAT = 4;

endpackage

// File: rtl/xnor_seq_packer.sv
// Packs 1-bit neuron results into OUT_W-bit words and holds each word on a
// valid/ready stream until it is accepted.
//   sample_en : write cmp into the next free bit
//   cmp       : engine compare bit for the current neuron
//   last_in   : the neuron being sampled is the last of the layer
//   emit      : FSM is presenting the current word
//   out_ready : downstream accept
//   word_done : the sample happening now completes a word
//   out_valid/out_data/out_last : output stream
module xnor_seq_packer #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sample_en,
    input  logic             cmp,
    input  logic             last_in,
    input  logic             emit,
    input  logic             out_ready,
    output logic             word_done,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int BW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [OUT_W-1:0] data_q, data_d;
    logic [BW-1:0]    idx_q, idx_d;
    logic             last_q, last_d;
    logic             ack;

    assign ack       = emit & out_ready;
    assign word_done = (idx_q == BW'(OUT_W - 1)) || last_in;

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        last_d = last_q;
        if (sample_en) begin
            data_d[idx_q] = cmp;
            idx_d         = idx_q + BW'(1);
            last_d        = last_in;
        end
        // Accepted word: start the next one empty so a partial final word
        // never carries stale upper bits.
        if (ack) begin
            data_d = '0;
            idx_d  = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    assign out_valid = emit;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/xnor_pop_sequencer.sv
// Sequences the XNOR-popcount neuron engine: per neuron clear, issue chunk
// addresses, wait out the engine pipeline, sample the compare bit; results
// are packed into activation words for the next layer.
//   clk/rstn (sync, active-low), start/num_chunks/num_neurons, busy/done
//   eng_clr/eng_we/eng_addr/eng_neuron/eng_cmp : engine interface
//   out_valid/out_ready/out_data/out_last      : activation word stream
// Optional: define XNOR_SEQ_PERF_EN for perf_cycles (busy cycles) and
// perf_stall (EMIT cycles with out_ready low), saturating 32-bit counters.
module xnor_pop_sequencer
    import xnor_pop_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAXN     = DEF_MAXN,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int AW       = $clog2(DEPTH),
    parameter int NW       = $clog2(MAXN)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [AW:0]      num_chunks,
    input  logic [NW:0]      num_neurons,
    output logic             busy,
    output logic             done,
    output logic             eng_clr,
    output logic             eng_we,
    output logic [AW-1:0]    eng_addr,
    output logic [NW-1:0]    eng_neuron,
    input  logic             eng_cmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
`ifdef XNOR_SEQ_PERF_EN
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall,
`endif
    output logic             out_last
);

    localparam int LW = $clog2(PIPE_LAT + 1);
    localparam logic [AW:0] ONE_C = 1;
    localparam logic [NW:0] ONE_N = 1;

    state_e        state_q, state_d;
    logic [AW:0]   nch_q, nch_d;
    logic [NW:0]   nn_q, nn_d;
    logic [AW-1:0] addr_q, addr_d;
    // One bit wider than eng_neuron so it can count past the last neuron.
    logic [NW:0]   neuron_q, neuron_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          done_q, done_d;

    logic last_neuron, word_done, last_word, start_ok;

    assign last_neuron = (neuron_q == nn_q - ONE_N);
    assign start_ok    = start && (state_q == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            nch_q    <= '0;
            nn_q     <= '0;
            addr_q   <= '0;
            neuron_q <= '0;
            lat_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nch_q    <= nch_d;
            nn_q     <= nn_d;
            addr_q   <= addr_d;
            neuron_q <= neuron_d;
            lat_q    <= lat_d;
            done_q   <= done_d;
        end
    end

    // Next state and counters
    always_comb begin
        state_d  = state_q;
        nch_d    = nch_q;
        nn_d     = nn_q;
        addr_d   = addr_q;
        neuron_d = neuron_q;
        lat_d    = lat_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_chunks == '0 || num_neurons == '0) begin
                        done_d = 1'b1;
                    end else begin
                        nch_d    = num_chunks;
                        nn_d     = num_neurons;
                        neuron_d = '0;
                        addr_d   = '0;
                        state_d  = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                addr_d  = '0;
                lat_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Address stays on the last chunk through DRAIN.
                if ({1'b0, addr_q} == nch_q - ONE_C) state_d = ST_DRAIN;
                else                                 addr_d  = addr_q + AW'(1);
            end
            ST_DRAIN: begin
                if (lat_q == LW'(PIPE_LAT - 1)) state_d = ST_SAMPLE;
                else                            lat_d   = lat_q + LW'(1);
            end
            ST_SAMPLE: begin
                neuron_d = neuron_q + ONE_N;
                state_d  = word_done ? ST_EMIT : ST_CLEAR;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last_word) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = done_q;
        eng_clr    = (state_q == ST_CLEAR);
        eng_we     = 1'b0;
        eng_addr   = addr_q;
        eng_neuron = neuron_q[NW-1:0];
    end

    xnor_seq_packer #(.OUT_W(OUT_W)) u_packer (
        .clk       (clk),
        .rstn      (rstn),
        .sample_en (state_q == ST_SAMPLE),
        .cmp       (eng_cmp),
        .last_in   (last_neuron),
        .emit      (state_q == ST_EMIT),
        .out_ready (out_ready),
        .word_done (word_done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (last_word)
    );

    assign out_last = last_word;

`ifdef XNOR_SEQ_PERF_EN
    logic [31:0] cyc_q, cyc_d, stall_q, stall_d;

    always_comb begin
        cyc_d   = cyc_q;
        stall_d = stall_q;
        if (start_ok) begin
            cyc_d   = '0;
            stall_d = '0;
        end else begin
            if (busy && cyc_q != '1) cyc_d = cyc_q + 32'd1;
            if (state_q == ST_EMIT && !out_ready && stall_q != '1)
                stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            stall_q <= stall_d;
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_stall  = stall_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_xnor_pop_sequencer.sv
module tb_xnor_pop_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [3:0] num_chunks;
    logic [6:0] num_neurons;
    logic       busy, done, eng_clr, eng_we;
    logic [2:0] eng_addr;
    logic [5:0] eng_neuron;
    logic       eng_cmp;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
`ifdef XNOR_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    always #5 clk = ~clk;

    xnor_pop_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start),
        .num_chunks(num_chunks), .num_neurons(num_neurons),
        .busy(busy), .done(done), .eng_clr(eng_clr), .eng_we(eng_we),
        .eng_addr(eng_addr), .eng_neuron(eng_neuron), .eng_cmp(eng_cmp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef XNOR_SEQ_PERF_EN
        .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
        .out_last(out_last)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } word_t;

    word_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cur_mode = 0;
    int cur_nch  = 1;
    int clr_cnt  = 0;
    bit cap_on   = 0;
    int cap_i    = 0;

    function automatic logic model_bit(int n, int mode);
        case (mode)
            0:       return (n % 2) == 1;
            1:       return 1'b1;
            default: return (n % 3) == 0;
        endcase
    endfunction

    always_comb eng_cmp = model_bit(int'(eng_neuron), cur_mode);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(int nn, int mode);
        logic [7:0] w = '0;
        int k = 0;
        for (int n = 0; n < nn; n++) begin
            w[k] = model_bit(n, mode);
            k++;
            if (k == 8 || n == nn - 1) begin
                q.push_back('{data: w, last: (n == nn - 1)});
                w = '0;
                k = 0;
            end
        end
    endtask

    // Monitor: address sequence after each clear, clear count, word scoreboard.
    always @(negedge clk) begin
        if (!rstn) begin
            cap_on = 0;
        end else begin
            if (eng_clr) begin
                clr_cnt++;
                cap_on = 1;
                cap_i  = 0;
            end else if (cap_on) begin
                check("eng_addr_seq", eng_addr, cap_i);
                cap_i++;
                if (cap_i == cur_nch) cap_on = 0;
            end
            if (out_valid && out_ready) begin
                check("word_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    word_t e;
                    e = q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    task automatic pulse_start(int nch, int nn);
        @(posedge clk); #1;
        num_chunks  = 4'(nch);
        num_neurons = 7'(nn);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(int budget);
        int c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
    endtask

    task automatic run_layer(int nch, int nn, int mode);
        cur_mode = mode;
        cur_nch  = nch;
        clr_cnt  = 0;
        push_model(nn, mode);
        pulse_start(nch, nn);
        check("busy_after_start", busy, 1);
        wait_done(2000);
        check("clr_count", clr_cnt, nn);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; num_chunks = '0; num_neurons = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clr", eng_clr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_neuron", eng_neuron, 0);

        // Basic: odd neurons set -> 0xAA, last
        run_layer(3, 8, 0);
        check("eng_we", eng_we, 0);

        // Partial final word
        run_layer(2, 10, 1);

        // Mixed pattern, several words
        run_layer(8, 20, 2);

        // Zero-size layers
        for (int z = 0; z < 2; z++) begin
            clr_cnt = 0;
            pulse_start(z == 0 ? 0 : 4, z == 0 ? 5 : 0);
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("zero_no_valid", out_valid, 0);
                check("zero_no_busy", busy, 0);
            end
            check("zero_no_clr", clr_cnt, 0);
        end

        // Backpressure on first word of a two-word layer (0x49, then 0x02 last)
        cur_mode = 2; cur_nch = 2; clr_cnt = 0;
        push_model(10, 2);
        @(posedge clk); #1 out_ready = 1'b0;
        pulse_start(2, 10);
        begin
            int c = 0;
            while (!out_valid && c < 500) begin @(negedge clk); c++; end
        end
        check("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", out_valid, 1);
            check("bp_data_hold", out_data, 8'h49);
            check("bp_last_hold", out_last, 0);
            check("bp_no_clr", eng_clr, 0);
            @(negedge clk);
        end
        check("bp_clr_before_ack", clr_cnt, 8);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(2000);
        check("bp_queue_drained", q.size(), 0);
        check("bp_clr_count", clr_cnt, 10);

        // Reset during DRAIN of neuron 3
        cur_mode = 0; cur_nch = 3; clr_cnt = 0;
        push_model(8, 0);
        pulse_start(3, 8);
        begin
            int c = 0;
            while (clr_cnt < 4 && c < 500) begin @(negedge clk); c++; end
        end
        check("mid_neuron_idx", eng_neuron, 3);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check("mid_still_busy", busy, 1);
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_clr", eng_clr, 0);
        check("mrst_we", eng_we, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_last", out_last, 0);
        check("mrst_addr", eng_addr, 0);
        check("mrst_neuron", eng_neuron, 0);
        check("mrst_data", out_data, 0);
`ifdef XNOR_SEQ_PERF_EN
        check("mrst_perf_cycles", perf_cycles, 0);
        check("mrst_perf_stall", perf_stall, 0);
`endif
        q.delete();
        @(posedge clk); #1 rstn = 1'b1;
        run_layer(3, 8, 0);

`ifdef XNOR_SEQ_PERF_EN
        run_layer(1, 1, 1);
        check("perf_cycles", perf_cycles, 8);
        check("perf_stall", perf_stall, 0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
